imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
Registered, parametrised immediate-generation stage for the decode pipeline. It accepts a 32-bit instruction with an opaque tag (typically the PC) over a valid/ready handshake, then presents the sign/zero-extended immediate, a format code and an illegal-opcode flag one cycle later. Generalises the combinational RV32I immediate generator to XLEN = 32 or 64, adds OP-IMM-32 and RV64 shamt handling, and adds a 2-entry skid buffer for full-throughput backpressure and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 and 64 only (elaboration error otherwise)
TAG_W, 32, width of the pass-through tag

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous pipeline flush; discards all held entries
in_valid  input  1  upstream has an instruction
in_ready  output  1  stage can accept; equals !skid_valid, forced 0 while reset high
in_instr  input  32  instruction word
in_tag  input  TAG_W  pass-through tag
out_valid  output  1  out_* fields hold a valid entry
out_ready  input  1  downstream accepts
out_imm  output  XLEN  generated immediate
out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
out_illegal  output  1  opcode not recognised
out_tag  output  TAG_W  tag of the presented entry

Behaviour:
- Decode (combinational on in_instr, registered on accept), by opcode [6:0]:
  - 0010011 OP-IMM: funct3 001/101 -> SHAMT, zero-extended in_instr[24:20] (XLEN=32) or [25:20] (XLEN=64); otherwise I, sign-extended [31:20].
  - 0011011 OP-IMM-32: legal only when XLEN=64; funct3 001/101 -> SHAMT, zero-extended [24:20]; otherwise I. With XLEN=32 -> illegal.
  - 0000011 LOAD, 1100111 JALR -> I.
  - 0100011 -> S: sign-extended {[31:25],[11:7]}.
  - 1100011 -> B: sign-extended {[31],[7],[30:25],[11:8],0}.
  - 0110111 LUI, 0010111 AUIPC -> U: {[31:12],12'b0}, sign-extended from bit 31 to XLEN.
  - 1101111 -> J: sign-extended {[31],[19:12],[20],[30:21],0}.
  - Any other opcode: imm = 0, fmt = NONE, illegal = 1. Illegal entries still flow through the handshake.
  - Sign extension always replicates in_instr[31] up to XLEN.
- Storage: main register (drives out_*) plus skid register, each with a valid bit. State is EMPTY, ONE (main only) or TWO (main + skid).
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- EMPTY: on accept -> ONE; new entry enters main.
- ONE: accept & pop -> ONE, new entry replaces main. Accept only -> TWO, new entry enters skid. Pop only -> EMPTY.
- TWO: in_ready = 0. Pop -> ONE, skid moves to main. No pop -> hold.
- Latency: accept at edge N -> out_valid at N+1 with no bubble. Sustains 1 entry/cycle with out_ready held high.
- Ordering: strictly FIFO; no loss or duplication under any in_valid/out_ready pattern.
- out_* stay stable while out_valid=1 and out_ready=0.
- flush: at the next edge both valid bits clear and the state becomes EMPTY. An accept or pop in the same cycle is discarded. flush has priority over all transitions.
- reset has priority over flush.
- Reset values: out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, skid contents 0; in_ready=1 from the first cycle after reset deasserts.
- Data registers load only on accept or skid-to-main move (no toggling when idle).

Test Plan:
1. XLEN=32, in 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0, out_tag echoed.
2. XLEN=32, in 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, out_fmt=3. Then 0x0000007F -> out_imm=0, out_fmt=0, out_illegal=1.
3. XLEN=64: 0x43F0D093 (srai x1,x1,63) -> out_imm=63, out_fmt=6; 0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000, out_fmt=4; 0x0000009B (addiw) -> fmt 1, illegal 0. Same 0x0000009B at XLEN=32 -> illegal=1.
4. Backpressure: out_ready=0, tags 1,2,3 offered back-to-back -> tag1 in main, tag2 in skid, in_ready=0 with tag3 held. Raise out_ready -> outputs tags 1,2,3 on consecutive cycles with no gaps or duplicates.
5. 100 random instructions, random in_valid/out_ready -> scoreboard matches the golden decode in order; out_* stable whenever stalled.
6. State TWO with in_valid=1, assert flush one cycle -> next cycle out_valid=0, in_ready=1, and none of the three entries ever appears. Reset asserted mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/imm_gen_stage.sv
// +----------------------------------------------------------------------------+
// | imm_gen_stage: registered RV32/RV64 immediate generator, 2-entry skid buf. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    localparam logic [2:0] c_FMT_NONE  = 3'd0;
    localparam logic [2:0] c_FMT_I     = 3'd1;
    localparam logic [2:0] c_FMT_S     = 3'd2;
    localparam logic [2:0] c_FMT_B     = 3'd3;
    localparam logic [2:0] c_FMT_U     = 3'd4;
    localparam logic [2:0] c_FMT_J     = 3'd5;
    localparam logic [2:0] c_FMT_SHAMT = 3'd6;

    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic            w_is_shift;
    logic [31:0]     w_imm_i;

    assign w_is_shift = (in_instr[14:12] == 3'b001) || (in_instr[14:12] == 3'b101);
    assign w_imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};

    // All formats fit in 32 bits; widening to XLEN is a pure sign extension.
    always_comb begin
        w_imm32   = 32'd0;
        w_fmt     = c_FMT_NONE;
        w_illegal = 1'b0;
        case (in_instr[6:0])
            c_OP_IMM: begin
                if (w_is_shift) begin
                    w_fmt   = c_FMT_SHAMT;
                    w_imm32 = (XLEN == 64) ? {26'd0, in_instr[25:20]}
                                           : {27'd0, in_instr[24:20]};
                end else begin
                    w_fmt   = c_FMT_I;
                    w_imm32 = w_imm_i;
                end
            end
            c_OP_IMM32: begin
                if (XLEN != 64) begin
                    w_illegal = 1'b1;
                end else if (w_is_shift) begin
                    w_fmt   = c_FMT_SHAMT;
                    w_imm32 = {27'd0, in_instr[24:20]};
                end else begin
                    w_fmt   = c_FMT_I;
                    w_imm32 = w_imm_i;
                end
            end
            c_OP_LOAD, c_OP_JALR: begin
                w_fmt   = c_FMT_I;
                w_imm32 = w_imm_i;
            end
            c_OP_STORE: begin
                w_fmt   = c_FMT_S;
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            c_OP_BRANCH: begin
                w_fmt   = c_FMT_B;
                w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_fmt   = c_FMT_U;
                w_imm32 = {in_instr[31:12], 12'd0};
            end
            c_OP_JAL: begin
                w_fmt   = c_FMT_J;
                w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    if (XLEN == 64) begin : g_xlen64
        assign w_imm = {{32{w_imm32[31]}}, w_imm32};
    end else begin : g_xlen32
        assign w_imm = w_imm32;
    end

    logic [1:0]       state_q,       state_d;
    logic [XLEN-1:0]  main_imm_q,    main_imm_d;
    logic [2:0]       main_fmt_q,    main_fmt_d;
    logic             main_ill_q,    main_ill_d;
    logic [TAG_W-1:0] main_tag_q,    main_tag_d;
    logic [XLEN-1:0]  skid_imm_q,    skid_imm_d;
    logic [2:0]       skid_fmt_q,    skid_fmt_d;
    logic             skid_ill_q,    skid_ill_d;
    logic [TAG_W-1:0] skid_tag_q,    skid_tag_d;

    logic w_accept;
    logic w_pop;

    assign in_ready    = !reset && (state_q != c_ST_TWO);
    assign out_valid   = (state_q != c_ST_EMPTY);
    assign w_accept    = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign out_imm     = main_imm_q;
    assign out_fmt     = main_fmt_q;
    assign out_illegal = main_ill_q;
    assign out_tag     = main_tag_q;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_fmt_d = main_fmt_q;
        main_ill_d = main_ill_q;
        main_tag_d = main_tag_q;
        skid_imm_d = skid_imm_q;
        skid_fmt_d = skid_fmt_q;
        skid_ill_d = skid_ill_q;
        skid_tag_d = skid_tag_q;
        if (flush) begin
            state_d = c_ST_EMPTY;
        end else begin
            case (state_q)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        state_d    = c_ST_ONE;
                        main_imm_d = w_imm;
                        main_fmt_d = w_fmt;
                        main_ill_d = w_illegal;
                        main_tag_d = in_tag;
                    end
                end
                c_ST_ONE: begin
                    if (w_accept && w_pop) begin
                        main_imm_d = w_imm;
                        main_fmt_d = w_fmt;
                        main_ill_d = w_illegal;
                        main_tag_d = in_tag;
                    end else if (w_accept) begin
                        state_d    = c_ST_TWO;
                        skid_imm_d = w_imm;
                        skid_fmt_d = w_fmt;
                        skid_ill_d = w_illegal;
                        skid_tag_d = in_tag;
                    end else if (w_pop) begin
                        state_d = c_ST_EMPTY;
                    end
                end
                c_ST_TWO: begin
                    if (w_pop) begin
                        state_d    = c_ST_ONE;
                        main_imm_d = skid_imm_q;
                        main_fmt_d = skid_fmt_q;
                        main_ill_d = skid_ill_q;
                        main_tag_d = skid_tag_q;
                    end
                end
                default: begin
                    state_d = c_ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= c_ST_EMPTY;
            main_imm_q <= '0;
            main_fmt_q <= '0;
            main_ill_q <= 1'b0;
            main_tag_q <= '0;
            skid_imm_q <= '0;
            skid_fmt_q <= '0;
            skid_ill_q <= 1'b0;
            skid_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_fmt_q <= main_fmt_d;
            main_ill_q <= main_ill_d;
            main_tag_q <= main_tag_d;
            skid_imm_q <= skid_imm_d;
            skid_fmt_q <= skid_fmt_d;
            skid_ill_q <= skid_ill_d;
            skid_tag_q <= skid_tag_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
// +----------------------------------------------------------------------------+
// | tb_imm_gen_stage: bench for imm_gen_stage at XLEN=32 and XLEN=64 together.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_imm_gen_stage;

    localparam int TAG_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, flush, in_valid, out_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;

    logic             rdy32, vld32, ill32, rdy64, vld64, ill64;
    logic [31:0]      imm32;
    logic [63:0]      imm64;
    logic [2:0]       fmt32, fmt64;
    logic [TAG_W-1:0] tag32, tag64;

    imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
    );

    typedef struct {
        logic [31:0]      ins;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t q[$];
    int   passed = 0;
    int   total  = 0;

    // Reference decode straight from the ISA immediate layouts.
    function automatic void golden(input logic [31:0] ins, input int xlen,
                                   output logic [63:0] imm, output logic [2:0] fmt,
                                   output logic ill);
        longint     v;
        logic [2:0] f3;
        logic       sh;
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        f3  = ins[14:12];
        sh  = (f3 == 3'd1) || (f3 == 3'd5);
        case (ins[6:0])
            7'b0010011: begin
                if (sh) begin
                    fmt = 3'd6;
                    if (xlen == 64) v = longint'(ins[25:20]);
                    else            v = longint'(ins[24:20]);
                end else begin
                    fmt = 3'd1;
                    v   = longint'($signed(ins[31:20]));
                end
            end
            7'b0011011: begin
                if (xlen != 64)  ill = 1'b1;
                else if (sh) begin fmt = 3'd6; v = longint'(ins[24:20]); end
                else begin fmt = 3'd1; v = longint'($signed(ins[31:20])); end
            end
            7'b0000011, 7'b1100111: begin fmt = 3'd1; v = longint'($signed(ins[31:20])); end
            7'b0100011: begin fmt = 3'd2; v = longint'($signed({ins[31:25], ins[11:7]})); end
            7'b1100011: begin
                fmt = 3'd3;
                v   = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin fmt = 3'd4; v = longint'($signed({ins[31:12], 12'h000})); end
            7'b1101111: begin
                fmt = 3'd5;
                v   = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            default: ill = 1'b1;
        endcase
        imm = 64'(v);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 10))
            0:  r[6:0] = 7'b0010011;
            1:  r[6:0] = 7'b0011011;
            2:  r[6:0] = 7'b0000011;
            3:  r[6:0] = 7'b1100111;
            4:  r[6:0] = 7'b0100011;
            5:  r[6:0] = 7'b1100011;
            6:  r[6:0] = 7'b0110111;
            7:  r[6:0] = 7'b0010111;
            8:  r[6:0] = 7'b1101111;
            9:  r[14:12] = 3'b101;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) r[14:12] = 3'b001;
        return r;
    endfunction

    // Drives one cycle and advances the reference queue; no checking here.
    task automatic drive_cycle(input logic iv, input logic [31:0] ins,
                               input logic [TAG_W-1:0] tag, input logic ordy,
                               input logic fl, input logic rst);
        bit   acc, pop;
        ent_t e;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_instr  = ins;
        in_tag    = tag;
        out_ready = ordy;
        acc = iv && !rst && (q.size() < 2);
        pop = ordy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (rst || fl) begin
            q.delete();
        end else begin
            if (pop) q.delete(0);
            if (acc) begin
                e.ins = ins;
                e.tag = tag;
                q.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 32'hFFF00093, 32'h5, 1'b0, 1'b0, 1'b1);
        total++;
        if ({rdy32, rdy64} !== 2'b00) $display("FAIL reset_in_ready_low: got %b expected 00", {rdy32, rdy64});
        else passed++;
        drive_cycle(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({rdy32, vld32, imm32, fmt32, ill32, tag32} !== {1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0})
            $display("FAIL reset_state32: got rdy=%b vld=%b imm=%h fmt=%0d ill=%b tag=%h expected 1 0 0 0 0 0",
                     rdy32, vld32, imm32, fmt32, ill32, tag32);
        else passed++;
        total++;
        if ({rdy64, vld64, imm64, fmt64, ill64, tag64} !== {1'b1, 1'b0, 64'h0, 3'd0, 1'b0, 32'h0})
            $display("FAIL reset_state64: got rdy=%b vld=%b imm=%h fmt=%0d ill=%b tag=%h expected 1 0 0 0 0 0",
                     rdy64, vld64, imm64, fmt64, ill64, tag64);
        else passed++;
    endtask

    localparam logic [31:0] D_INS [8] = '{32'hFFF00093, 32'hFE000EE3, 32'h0000007F, 32'h43F0D093,
                                         32'h800000B7, 32'h0000009B, 32'hFE112C23, 32'h0010006F};
    localparam logic [31:0] D_IMM32 [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h1F,
                                           32'h80000000, 32'h0, 32'hFFFFFFF8, 32'h800};
    localparam logic [63:0] D_IMM64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h3F,
                                           64'hFFFFFFFF80000000, 64'h0, 64'hFFFFFFFFFFFFFFF8, 64'h800};
    localparam logic [2:0]  D_FMT32 [8] = '{3'd1, 3'd3, 3'd0, 3'd6, 3'd4, 3'd0, 3'd2, 3'd5};
    localparam logic [2:0]  D_FMT64 [8] = '{3'd1, 3'd3, 3'd0, 3'd6, 3'd4, 3'd1, 3'd2, 3'd5};
    localparam logic        D_ILL32 [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic        D_ILL64 [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic test_decode();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, D_INS[i], 32'h100 + i, 1'b1, 1'b0, 1'b0);
            total++;
            if ({vld32, imm32, fmt32, ill32, tag32} !== {1'b1, D_IMM32[i], D_FMT32[i], D_ILL32[i], 32'h100 + i})
                $display("FAIL decode32[%0d]: got vld=%b imm=%h fmt=%0d ill=%b tag=%h expected 1 %h %0d %b %h",
                         i, vld32, imm32, fmt32, ill32, tag32, D_IMM32[i], D_FMT32[i], D_ILL32[i], 32'h100 + i);
            else passed++;
            total++;
            if ({vld64, imm64, fmt64, ill64, tag64} !== {1'b1, D_IMM64[i], D_FMT64[i], D_ILL64[i], 32'h100 + i})
                $display("FAIL decode64[%0d]: got vld=%b imm=%h fmt=%0d ill=%b tag=%h expected 1 %h %0d %b %h",
                         i, vld64, imm64, fmt64, ill64, tag64, D_IMM64[i], D_FMT64[i], D_ILL64[i], 32'h100 + i);
            else passed++;
        end
        drive_cycle(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
        total++;
        if ({vld32, vld64} !== 2'b00) $display("FAIL decode_drain: got %b expected 00", {vld32, vld64});
        else passed++;
    endtask

    localparam logic       BP_IV   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic       BP_ORD  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [7:0] BP_TAG  [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd0};
    localparam logic       BP_VLD  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic       BP_RDY  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [7:0] BP_OTAG [6] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd0};

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(BP_IV[i], 32'h00A00093 + {24'd0, BP_TAG[i]}, {24'd0, BP_TAG[i]},
                        BP_ORD[i], 1'b0, 1'b0);
            total++;
            if ({vld32, rdy32, vld64, rdy64} !== {BP_VLD[i], BP_RDY[i], BP_VLD[i], BP_RDY[i]})
                $display("FAIL backpressure_hs[%0d]: got vld/rdy %b%b %b%b expected %b%b",
                         i, vld32, rdy32, vld64, rdy64, BP_VLD[i], BP_RDY[i]);
            else passed++;
            if (BP_VLD[i]) begin
                total++;
                if ({tag32, tag64} !== {24'd0, BP_OTAG[i], 24'd0, BP_OTAG[i]})
                    $display("FAIL backpressure_tag[%0d]: got %h/%h expected %h", i, tag32, tag64, BP_OTAG[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        int          acc_cnt = 0;
        int          cyc     = 0;
        logic        iv, ordy;
        logic [63:0] gi;
        logic [2:0]  gf;
        logic        gl;
        while ((acc_cnt < 100 || q.size() > 0) && cyc < 3000) begin
            iv   = (acc_cnt < 100) && ($urandom_range(0, 9) < 7);
            ordy = (acc_cnt >= 100) || ($urandom_range(0, 9) < 6);
            if (iv && q.size() < 2) acc_cnt++;
            drive_cycle(iv, rand_instr(), $urandom, ordy, 1'b0, 1'b0);
            cyc++;
            total++;
            if ({vld32, rdy32, vld64, rdy64} !== {q.size() > 0, q.size() < 2, q.size() > 0, q.size() < 2})
                $display("FAIL random_hs cyc %0d: got vld/rdy %b%b %b%b expected occupancy %0d",
                         cyc, vld32, rdy32, vld64, rdy64, q.size());
            else passed++;
            if (q.size() > 0) begin
                golden(q[0].ins, 32, gi, gf, gl);
                total++;
                if ({imm32, fmt32, ill32, tag32} !== {gi[31:0], gf, gl, q[0].tag})
                    $display("FAIL random32 ins %h: got imm=%h fmt=%0d ill=%b tag=%h expected %h %0d %b %h",
                             q[0].ins, imm32, fmt32, ill32, tag32, gi[31:0], gf, gl, q[0].tag);
                else passed++;
                golden(q[0].ins, 64, gi, gf, gl);
                total++;
                if ({imm64, fmt64, ill64, tag64} !== {gi, gf, gl, q[0].tag})
                    $display("FAIL random64 ins %h: got imm=%h fmt=%0d ill=%b tag=%h expected %h %0d %b %h",
                             q[0].ins, imm64, fmt64, ill64, tag64, gi, gf, gl, q[0].tag);
                else passed++;
            end
        end
        total++;
        if (acc_cnt < 100 || q.size() > 0)
            $display("FAIL random_budget: accepted %0d held %0d expected 100 accepted and drained", acc_cnt, q.size());
        else passed++;
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, 32'h00100093, 32'hA1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h00200093, 32'hA2, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h00300093, 32'hA3, 1'b1, 1'b1, 1'b0);
        total++;
        if ({vld32, rdy32, vld64, rdy64} !== 4'b0101)
            $display("FAIL flush_state: got vld/rdy %b%b %b%b expected 01 01", vld32, rdy32, vld64, rdy64);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
            total++;
            if ({vld32, vld64} !== 2'b00)
                $display("FAIL flush_ghost[%0d]: got vld %b%b tags %h/%h expected no entry", i, vld32, vld64, tag32, tag64);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 32'hFFF00093, 32'hB1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h800000B7, 32'hB2, 1'b0, 1'b0, 1'b1);
        total++;
        if ({rdy32, vld32, imm32, fmt32, ill32, tag32} !== {1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0})
            $display("FAIL reset_mid32: got rdy=%b vld=%b imm=%h fmt=%0d ill=%b tag=%h expected all 0",
                     rdy32, vld32, imm32, fmt32, ill32, tag32);
        else passed++;
        total++;
        if ({rdy64, vld64, imm64, fmt64, ill64, tag64} !== {1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 32'h0})
            $display("FAIL reset_mid64: got rdy=%b vld=%b imm=%h fmt=%0d ill=%b tag=%h expected all 0",
                     rdy64, vld64, imm64, fmt64, ill64, tag64);
        else passed++;
        drive_cycle(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
        total++;
        if ({vld32, rdy32, vld64, rdy64} !== 4'b0101)
            $display("FAIL reset_mid_release: got vld/rdy %b%b %b%b expected 01 01", vld32, rdy32, vld64, rdy64);
        else passed++;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_tag    = '0;
        out_ready = 1'b0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
